mul_serial_io: RTL

Parametrised sequential multiplier with a narrow, chunk-serial operand and product interface, the successor to the 7x7 combinational multiplier top. Operands of X_WIDTH bits arrive over an IO_WIDTH-bit bus as LSB-first chunks. A shift-add datapath computes the product one multiplier bit per cycle, in unsigned or two's-complement mode. The 2*X_WIDTH-bit product then leaves over the same-width output bus as LSB-first chunks. It sits directly behind the pad-level io_in/io_out wrapper, replacing the clock-edge in/out muxing.

---
 rtl/mul_serial_io_pkg.sv | 17 +
 rtl/mul_serial_io_core.sv | 73 +++++++
 rtl/mul_serial_io.sv | 107 ++++++++++
 3 files changed

// File: rtl/mul_serial_io_pkg.sv
// Shared types and defaults for the chunk-serial multiplier.
package mul_serial_io_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_MUL  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  localparam int DEF_IO_WIDTH = 7;
  localparam int DEF_X_WIDTH  = 7;

  function automatic bit params_legal(input int io_w, input int x_w);
    return (io_w >= 1) && (x_w >= 2) && ((x_w % io_w) == 0);
  endfunction

endpackage

// File: rtl/mul_serial_io_core.sv
// Shift-add multiplier datapath: operand shift-in, one multiplier bit per cycle.
module mul_seq_core
  import mul_serial_io_pkg::*;
#(
  parameter int IO_WIDTH = DEF_IO_WIDTH,
  parameter int X_WIDTH  = DEF_X_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   shift_en,
  input  logic [IO_WIDTH-1:0]    chunk,
  input  logic                   start,
  input  logic                   signed_in,
  output logic                   done,
  output logic [IO_WIDTH-1:0]    p_first,
  output logic [2*X_WIDTH-1:0]   p
);

  localparam int BW = $clog2(X_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(X_WIDTH - 1);

  // {q, m}: chunks enter at the top and walk down, so chunk 0 ends in m[LSBs]
  logic [2*X_WIDTH-1:0] opnd;
  logic [X_WIDTH-1:0]   m;
  logic [X_WIDTH-1:0]   q;
  logic [BW-1:0]        bit_cnt;
  logic                 running;
  logic [2*X_WIDTH-1:0] m_ext;
  logic [2*X_WIDTH-1:0] term;
  logic [2*X_WIDTH-1:0] p_next;

  assign m = opnd[X_WIDTH-1:0];
  assign q = opnd[2*X_WIDTH-1:X_WIDTH];

  always_comb begin
    m_ext = signed_in ? {{X_WIDTH{m[X_WIDTH-1]}}, m} : {{X_WIDTH{1'b0}}, m};
    term  = q[bit_cnt] ? (m_ext << bit_cnt) : '0;
    // the multiplier's sign bit carries negative weight
    if (signed_in && (bit_cnt == LAST_BIT))
      p_next = p - term;
    else
      p_next = p + term;
  end

  assign done    = running && (bit_cnt == LAST_BIT);
  assign p_first = p_next[IO_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      opnd    <= '0;
      p       <= '0;
      bit_cnt <= '0;
      running <= 1'b0;
    end else begin
      if (shift_en)
        opnd <= {chunk, opnd[2*X_WIDTH-1:IO_WIDTH]};
      if (start) begin
        p       <= '0;
        bit_cnt <= '0;
        running <= 1'b1;
      end else if (running) begin
        p <= p_next;
        if (bit_cnt == LAST_BIT) begin
          running <= 1'b0;
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mul_serial_io.sv
// Chunk-serial multiplier top: load/unload FSM, chunk counter and output muxing.
//   state   | meaning
//   ST_LOAD | accepting operand chunks (m first, then q)
//   ST_MUL  | core stepping through multiplier bits
//   ST_OUT  | streaming product chunks, LSB chunk first
module mul_serial_io
  import mul_serial_io_pkg::*;
#(
  parameter int IO_WIDTH = DEF_IO_WIDTH,
  parameter int X_WIDTH  = DEF_X_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IO_WIDTH-1:0] din,
  input  logic                din_valid,
  input  logic                signed_mode,
  output logic [IO_WIDTH-1:0] dout,
  output logic                dout_valid,
  output logic                busy
);

  localparam int N  = X_WIDTH / IO_WIDTH;
  localparam int CW = $clog2(2 * N);
  localparam logic [CW-1:0] LAST_CHUNK = CW'(2 * N - 1);

  if (!params_legal(IO_WIDTH, X_WIDTH)) begin : g_bad_params
    $error("mul_serial_io: X_WIDTH must be >= 2 and a multiple of IO_WIDTH >= 1");
  end

  state_t               state;
  logic [CW-1:0]        chunk_cnt;
  logic [CW-1:0]        nxt_cnt;
  logic                 sgn_cap;
  logic                 shift_en;
  logic                 start;
  logic                 core_done;
  logic [IO_WIDTH-1:0]  p_first;
  logic [2*X_WIDTH-1:0] p;

  assign nxt_cnt  = chunk_cnt + 1'b1;
  assign shift_en = (state == ST_LOAD) && din_valid;
  assign start    = shift_en && (chunk_cnt == LAST_CHUNK);

  mul_seq_core #(
    .IO_WIDTH(IO_WIDTH),
    .X_WIDTH (X_WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .chunk    (din),
    .start    (start),
    .signed_in(sgn_cap),
    .done     (core_done),
    .p_first  (p_first),
    .p        (p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_LOAD;
      chunk_cnt  <= '0;
      sgn_cap    <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (din_valid) begin
            if (chunk_cnt == '0)
              sgn_cap <= signed_mode;
            if (chunk_cnt == LAST_CHUNK) begin
              state     <= ST_MUL;
              chunk_cnt <= '0;
              busy      <= 1'b1;
            end else begin
              chunk_cnt <= nxt_cnt;
            end
          end
        end
        ST_MUL: begin
          // final product is not registered yet, so take chunk 0 from the adder
          if (core_done) begin
            state      <= ST_OUT;
            dout       <= p_first;
            dout_valid <= 1'b1;
          end
        end
        ST_OUT: begin
          if (chunk_cnt == LAST_CHUNK) begin
            state      <= ST_LOAD;
            chunk_cnt  <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
          end else begin
            chunk_cnt <= nxt_cnt;
            dout      <= p[nxt_cnt*IO_WIDTH +: IO_WIDTH];
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule
